// File: rtl/key_cmd_arbiter.sv
// Debounces four low-active direction buttons and offers one move command at a
// time to game logic over a valid/ready handshake, arbitrating round-robin.
module key_cmd_arbiter #(
  parameter int DB_CNT = 10,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  input  logic       cmd_ready,
  output logic [3:0] pending,
  output logic       overrun
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       press_evt;
  logic [3:0]       accept_mask;
  logic [3:0]       pending_nx;
  logic             overrun_nx;
  logic             accept;
  logic [1:0]       last_grant, last_grant_nx;
  logic [1:0]       dir_nx;
  logic [1:0]       sel;
  logic [1:0]       cand;
  logic             sel_found;

  // Per-key debounce counters: clear while released, saturate at all-ones so
  // a long hold passes through DB_CNT exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (key_n[i])
          cnt[i] <= '0;
        else if (cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    press_evt = '0;
    for (int unsigned i = 0; i < 4; i++)
      press_evt[i] = (cnt[i] == CNT_W'(DB_CNT));
  end

  assign accept    = (state == OFFER) && cmd_ready;
  assign cmd_valid = (state == OFFER);

  // A fresh press wins over a same-cycle acceptance so that press is not lost.
  always_comb begin
    accept_mask = '0;
    if (accept)
      accept_mask[cmd_dir] = 1'b1;
    pending_nx = press_evt | (pending & ~accept_mask);
    overrun_nx = |(press_evt & pending & ~accept_mask);
  end

  always_comb begin
    sel       = '0;
    cand      = '0;
    sel_found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!sel_found && pending[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    dir_nx        = cmd_dir;
    last_grant_nx = last_grant;
    case (state)
      IDLE: begin
        if (sel_found) begin
          dir_nx   = sel;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (cmd_ready) begin
          last_grant_nx = cmd_dir;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_dir    <= '0;
      last_grant <= 2'd3;
      pending    <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      cmd_dir    <= dir_nx;
      last_grant <= last_grant_nx;
      pending    <= pending_nx;
      overrun    <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_key_cmd_arbiter.sv
// Directed bench for key_cmd_arbiter: latency, bounce rejection, round-robin
// order, overrun, reset during an offer and press/accept collision.
module tb_key_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic [3:0] pending;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_cmd_arbiter #(
    .DB_CNT(10),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_n    (key_n),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_ready(cmd_ready),
    .pending  (pending),
    .overrun  (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int first;
    int vcnt;
    int ov;
    int seen;
    logic [1:0] fdir;
    int dirs[$];
    int times[$];

    rst       = 1'b1;
    key_n     = 4'hF;
    cmd_ready = 1'b0;
    step();
    step();
    check("rst_valid",   32'(cmd_valid), 32'd0);
    check("rst_dir",     32'(cmd_dir),   32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    rst = 1'b0;

    // Single long press of key 0 with the consumer always ready.
    key_n     = 4'b1110;
    cmd_ready = 1'b1;
    first     = -1;
    vcnt      = 0;
    fdir      = '0;
    for (int t = 1; t <= 30; t++) begin
      step();
      if (t == 10) check("t1_pend_early", 32'(pending), 32'd0);
      if (t == 11) check("t1_pend_set",   32'(pending), 32'd1);
      if (cmd_valid) begin
        vcnt++;
        if (first < 0) begin
          first = t;
          fdir  = cmd_dir;
        end
      end
    end
    check("t1_latency", 32'(first), 32'd12);
    check("t1_count",   32'(vcnt),  32'd1);
    check("t1_dir",     32'(fdir),  32'd0);
    check("t1_pend_end", 32'(pending), 32'd0);
    key_n = 4'hF;
    for (int t = 0; t < 3; t++) step();

    // Key 2 bouncing: never DB_CNT consecutive low samples.
    seen = 0;
    for (int r = 0; r < 5; r++) begin
      key_n = 4'b1011;
      for (int t = 0; t < 9; t++) begin
        step();
        if (pending != 4'd0 || cmd_valid) seen++;
      end
      key_n = 4'hF;
      step();
      if (pending != 4'd0 || cmd_valid) seen++;
    end
    for (int t = 0; t < 3; t++) begin
      step();
      if (pending != 4'd0 || cmd_valid) seen++;
    end
    check("t2_bounce_quiet", 32'(seen), 32'd0);

    // Two rounds of all four keys pressed together.
    for (int r = 0; r < 2; r++) begin
      if (r == 0) do_reset();
      cmd_ready = 1'b1;
      key_n     = 4'h0;
      dirs.delete();
      times.delete();
      for (int t = 1; t <= 25; t++) begin
        step();
        if (cmd_valid) begin
          dirs.push_back(int'(cmd_dir));
          times.push_back(t);
        end
      end
      check($sformatf("t3_r%0d_count", r), 32'(dirs.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < dirs.size()) begin
          check($sformatf("t3_r%0d_dir%0d", r, k),  32'(dirs[k]),  32'(k));
          check($sformatf("t3_r%0d_time%0d", r, k), 32'(times[k]), 32'(12 + 2 * k));
        end
      end
      key_n = 4'hF;
      step();
      step();
    end

    // Key 1 held in offer, released and pressed again: overrun.
    do_reset();
    cmd_ready = 1'b0;
    key_n     = 4'b1101;
    for (int t = 0; t < 12; t++) step();
    check("t4_offer_valid", 32'(cmd_valid), 32'd1);
    check("t4_offer_dir",   32'(cmd_dir),   32'd1);
    key_n = 4'hF;
    step();
    key_n = 4'b1101;
    ov    = 0;
    for (int t = 1; t <= 15; t++) begin
      step();
      if (overrun) ov++;
      if (t == 11) check("t4_ov_at11", 32'(overrun), 32'd1);
    end
    check("t4_ov_count", 32'(ov),        32'd1);
    check("t4_dir_hold", 32'(cmd_dir),   32'd1);
    check("t4_valid",    32'(cmd_valid), 32'd1);
    check("t4_pending",  32'(pending),   32'b0010);

    // Reset mid-offer with key 3 held low through reset.
    key_n = 4'b0111;
    for (int t = 0; t < 3; t++) step();
    do_reset();
    check("t5_valid",   32'(cmd_valid), 32'd0);
    check("t5_pending", 32'(pending),   32'd0);
    check("t5_overrun", 32'(overrun),   32'd0);
    check("t5_dir",     32'(cmd_dir),   32'd0);
    for (int t = 1; t <= 12; t++) begin
      step();
      if (t == 11) check("t5_valid_11", 32'(cmd_valid), 32'd0);
      if (t == 12) begin
        check("t5_valid_12", 32'(cmd_valid), 32'd1);
        check("t5_dir_12",   32'(cmd_dir),   32'd3);
      end
    end

    // Key 3 re-press event lands on the same edge as acceptance of key 3.
    key_n = 4'hF;
    step();
    key_n = 4'b0111;
    for (int t = 0; t < 10; t++) step();
    check("t6_pre_valid",   32'(cmd_valid), 32'd1);
    check("t6_pre_pending", 32'(pending),   32'b1000);
    cmd_ready = 1'b1;
    step();
    check("t6_acc_valid",   32'(cmd_valid), 32'd0);
    check("t6_acc_pending", 32'(pending),   32'b1000);
    check("t6_acc_overrun", 32'(overrun),   32'd0);
    step();
    check("t6_reoffer_valid", 32'(cmd_valid), 32'd1);
    check("t6_reoffer_dir",   32'(cmd_dir),   32'd3);
    step();
    check("t6_done_valid",   32'(cmd_valid), 32'd0);
    check("t6_done_pending", 32'(pending),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_cmd_arbiter.md
KEY_CMD_ARBITER -- requirements
Module: key_cmd_arbiter

Interface
REQ-001 Parameter DB_CNT, default 10: consecutive low samples that qualify a press; legal range 1..62.
REQ-002 Parameter CNT_W, default 6: width of each per-key debounce counter; saturation value is 2^CNT_W-1 = 63.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 key_n  in  4  raw low-active buttons: [0]=up, [1]=down, [2]=left, [3]=right.
REQ-006 cmd_valid  out  1  move command offered to game logic.
REQ-007 cmd_dir  out  2  direction index of the offered command (0..3, same encoding as key_n bits).
REQ-008 cmd_ready  in  1  game logic accepts the command when high with cmd_valid.
REQ-009 pending  out  4  per-key press-waiting flags.
REQ-010 overrun  out  1  one-cycle pulse: a press was lost because that key was already pending.

Function
REQ-011 Each key i SHALL have a CNT_W-bit counter: key_n[i]==1 -> 0; else if counter==63 -> hold; else counter+1.
REQ-012 press_evt[i] SHALL be true in exactly the cycles where counter[i]==DB_CNT; since the counter saturates above DB_CNT, there SHALL be exactly one event per continuous low period of at least DB_CNT samples.
REQ-013 A low period shorter than DB_CNT samples (bounce) SHALL produce no event.
REQ-014 On press_evt[i], pending[i] SHALL be set at the next edge.
REQ-015 pending[i] SHALL clear at the edge where key i's command is accepted.
REQ-016 If press_evt[i] and acceptance of key i occur in the same cycle, pending[i] SHALL remain 1.
REQ-017 If press_evt[i] occurs while pending[i]==1 and key i is not being accepted that cycle, overrun SHALL pulse high for one cycle at the next edge, and pending[i] SHALL stay 1.
REQ-018 FSM states: IDLE, OFFER.
REQ-019 In IDLE with any pending bit set, the FSM SHALL select the first pending key searching round-robin from (last_grant+1) mod 4.
REQ-020 In that case the FSM SHALL register the selected index into cmd_dir and enter OFFER; cmd_valid is 1 from the next cycle.
REQ-021 In IDLE with no pending bit set, the FSM SHALL stay in IDLE with cmd_valid=0.
REQ-022 In OFFER, cmd_valid SHALL be 1 and cmd_dir SHALL be held stable until acceptance; keys pressed meanwhile only set pending.
REQ-023 In OFFER with cmd_ready==1: accept, clear pending[cmd_dir] (subject to REQ-016), set last_grant=cmd_dir, return to IDLE; cmd_valid is 0 in the following cycle.
REQ-024 The minimum spacing between accepted commands SHALL be 2 cycles.
REQ-025 Latency: with key_n[i] first sampled low at edge 1 and held low, and no other activity:
- counter==DB_CNT after edge DB_CNT;
- pending[i]=1 after edge DB_CNT+1;
- cmd_valid=1 with cmd_dir=i after edge DB_CNT+2.
REQ-026 cmd_ready while cmd_valid==0 SHALL be ignored.

Reset
REQ-027 rst high at an edge SHALL reset, regardless of FSM state:
- all counters=0, pending=0, overrun=0;
- cmd_valid=0, cmd_dir=0;
- FSM=IDLE, last_grant=3 (so the first search starts at key 0).
REQ-028 Reset mid-OFFER SHALL discard the offered command with no acceptance side effects.
REQ-029 A key held low through reset SHALL count from 0 after reset release and generate an event after DB_CNT further samples.

Verification
REQ-030 DB_CNT=10; key_n[0] low for 30 cycles, cmd_ready=1 -> cmd_valid high exactly 1 cycle, 12 cycles after first low sample, cmd_dir=0; exactly one command for the whole press.
REQ-031 key_n[2] bounces low 9 cycles, high 1 cycle, repeated 5 times -> no pending, no cmd_valid.
REQ-032 All four keys pressed together, cmd_ready=1 -> accepted order 0,1,2,3 at 2-cycle spacing; a second simultaneous round -> order 0,1,2,3 again (last_grant=3).
REQ-033 cmd_ready=0 while key 1 is offered; key 1 released and re-pressed ≥10 cycles -> overrun pulses once; cmd_dir stays 1; pending[1]=1.
REQ-034 rst asserted for 1 cycle while in OFFER -> next cycle cmd_valid=0, pending=0; a key held low through reset yields cmd_valid 12 cycles after reset deassertion.
REQ-035 Key 3 event coincides with acceptance of key 3 -> pending[3] stays 1 and a second cmd_dir=3 is offered 2 cycles later.
